// File: rtl/mips_defs.sv
// Shared fetch-path constants, FSM encoding and the fetch-address legality check.
package mips_defs;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC  = 32'h0000_4180;
  localparam logic [31:0] PC_LO    = 32'h0000_3000;
  localparam logic [31:0] PC_HI    = 32'h0000_6ffc;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_FULL = 2'd2
  } fetch_state_e;

  // Misaligned or outside the instruction window raises AdEL instead of a fetch.
  function automatic logic pc_illegal(input logic [31:0] pc);
    return (|pc[1:0]) | (pc < PC_LO) | (pc > PC_HI);
  endfunction

endpackage

// File: rtl/fetch_redirect_mux.sv
// Fixed-priority selection of the fetch redirect target: eret > exception > branch.
module fetch_redirect_mux
  import mips_defs::*;
(
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        exc_req,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        redir,
  output logic [31:0] tgt
);

  // Priority select of the redirect target
  always_comb begin
    redir = eret | exc_req | br_taken;
    if (eret) begin
      tgt = epc;
    end else if (exc_req) begin
      tgt = EXC_VEC;
    end else begin
      tgt = br_target;
    end
  end

endmodule

// File: rtl/if_fetch_ctrl_chk.sv
// Protocol checker: a memory response must only arrive for an outstanding granted request.
module if_fetch_ctrl_chk (
  input logic CLK,
  input logic Reset,
  input logic im_req,
  input logic im_gnt,
  input logic im_rvalid
);

  logic outstanding_r;

  // Track whether a granted request is still awaiting its response
  always_ff @(posedge CLK) begin
    if (Reset) begin
      outstanding_r <= 1'b0;
    end else if (im_req && im_gnt) begin
      outstanding_r <= 1'b1;
    end else if (im_rvalid) begin
      outstanding_r <= 1'b0;
    end else begin
      outstanding_r <= outstanding_r;
    end
  end

  a_rvalid_only_when_waiting : assert property (
    @(posedge CLK) disable iff (Reset) im_rvalid |-> outstanding_r
  );

endmodule

// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch sequencer: owns the fetch PC, issues one request at a time and holds
// the returned instruction for ID, dropping responses made stale by a redirect.
module if_fetch_ctrl
  import mips_defs::*;
(
  input  logic        CLK,
  input  logic        Reset,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        exc_req,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_gnt,
  input  logic        im_rvalid,
  input  logic [31:0] im_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_adel
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic         drop_q;
  logic         redir_s;
  logic [31:0]  tgt_s;
  logic         bad_s;

  fetch_redirect_mux u_redirect_mux (
    .eret      (eret),
    .epc       (epc),
    .exc_req   (exc_req),
    .br_taken  (br_taken),
    .br_target (br_target),
    .redir     (redir_s),
    .tgt       (tgt_s)
  );

  assign bad_s   = pc_illegal(pc_q);
  assign im_req  = (state_q == S_REQ) && !bad_s;
  assign im_addr = pc_q;

  // Fetch FSM with PC, stale-response flag and the ID holding register
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      drop_q   <= 1'b0;
      if_valid <= 1'b0;
      if_pc    <= RESET_PC;
      if_instr <= 32'h0000_0000;
      if_adel  <= 1'b0;
    end else begin
      case (state_q)
        S_REQ: begin
          if (!bad_s) begin
            if (im_gnt) begin
              // A redirect arriving with the grant makes this request stale at once.
              state_q <= S_WAIT;
              drop_q  <= redir_s;
              if (redir_s) begin
                pc_q <= tgt_s;
              end else begin
                pc_q <= pc_q;
              end
            end else if (redir_s) begin
              pc_q <= tgt_s;
            end else begin
              pc_q <= pc_q;
            end
          end else if (redir_s) begin
            pc_q <= tgt_s;
          end else begin
            state_q  <= S_FULL;
            if_valid <= 1'b1;
            if_adel  <= 1'b1;
            if_instr <= 32'h0000_0000;
            if_pc    <= pc_q;
          end
        end
        S_WAIT: begin
          if (redir_s) begin
            pc_q <= tgt_s;
            if (im_rvalid) begin
              drop_q  <= 1'b0;
              state_q <= S_REQ;
            end else begin
              drop_q <= 1'b1;
            end
          end else if (im_rvalid) begin
            if (drop_q) begin
              drop_q  <= 1'b0;
              state_q <= S_REQ;
            end else begin
              state_q  <= S_FULL;
              if_valid <= 1'b1;
              if_instr <= im_rdata;
              if_pc    <= pc_q;
              if_adel  <= 1'b0;
              pc_q     <= pc_q + 32'd4;
            end
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_FULL: begin
          if (redir_s) begin
            if_valid <= 1'b0;
            pc_q     <= tgt_s;
            state_q  <= S_REQ;
          end else if (if_ready) begin
            if_valid <= 1'b0;
            state_q  <= S_REQ;
          end else begin
            state_q <= S_FULL;
          end
        end
        default: begin
          state_q  <= S_REQ;
          drop_q   <= 1'b0;
          if_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed self-checking bench for if_fetch_ctrl with a variable-latency memory model.
module tb_if_fetch_ctrl;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        eret = 1'b0;
  logic [31:0] epc = 32'h0;
  logic        exc_req = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_gnt = 1'b0;
  logic        im_rvalid = 1'b0;
  logic [31:0] im_rdata = 32'h0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_adel;

  int checks = 0;
  int errors = 0;
  int mem_lat = 0;

  always #5 CLK = ~CLK;

  if_fetch_ctrl dut (
    .CLK(CLK), .Reset(Reset), .eret(eret), .epc(epc), .exc_req(exc_req),
    .br_taken(br_taken), .br_target(br_target), .im_req(im_req), .im_addr(im_addr),
    .im_gnt(im_gnt), .im_rvalid(im_rvalid), .im_rdata(im_rdata), .if_valid(if_valid),
    .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr), .if_adel(if_adel)
  );

  if_fetch_ctrl_chk u_chk (
    .CLK(CLK), .Reset(Reset), .im_req(im_req), .im_gnt(im_gnt), .im_rvalid(im_rvalid)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Memory model: one response mem_lat cycles after the cycle following a grant
  logic        pend = 1'b0;
  int          cnt = 0;
  logic [31:0] paddr = 32'h0;
  always @(posedge CLK) begin
    logic fired;
    logic rst_seen;
    logic [31:0] a;
    fired = im_req & im_gnt & ~Reset;
    rst_seen = Reset;
    a = im_addr;
    #1;
    im_rvalid = 1'b0;
    if (rst_seen) begin
      pend = 1'b0;
    end else begin
      if (fired) begin
        pend = 1'b1;
        cnt = mem_lat;
        paddr = a;
      end
      if (pend) begin
        if (cnt == 0) begin
          im_rvalid = 1'b1;
          im_rdata = mem_word(paddr);
          pend = 1'b0;
        end else begin
          cnt = cnt - 1;
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge CLK);
    Reset = 1'b1; eret = 1'b0; exc_req = 1'b0; br_taken = 1'b0;
    im_gnt = 1'b0; if_ready = 1'b0; mem_lat = 0;
    repeat (2) @(negedge CLK);
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", if_valid); end
    checks++; if (if_pc !== 32'h3000) begin errors++; $display("FAIL rst_pc got %h exp 3000", if_pc); end
    checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL rst_instr got %h exp 0", if_instr); end
    checks++; if (if_adel !== 1'b0) begin errors++; $display("FAIL rst_adel got %b exp 0", if_adel); end
    checks++; if (im_req !== 1'b1) begin errors++; $display("FAIL rst_req got %b exp 1", im_req); end
    checks++; if (im_addr !== 32'h3000) begin errors++; $display("FAIL rst_addr got %h exp 3000", im_addr); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp;
    int n;
    do_reset();
    mem_lat = 0; im_gnt = 1'b1; if_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp = 32'h3000 + 32'(4 * k);
      n = 0;
      while (im_req !== 1'b1 && n < 10) begin @(negedge CLK); n++; end
      checks++; if (im_req !== 1'b1) begin errors++; $display("FAIL seq_req_timeout k=%0d", k); end
      checks++; if (im_addr !== exp) begin errors++; $display("FAIL seq_addr got %h exp %h", im_addr, exp); end
      n = 0;
      while (if_valid !== 1'b1 && n < 10) begin @(negedge CLK); n++; end
      checks++; if (n !== 2) begin errors++; $display("FAIL seq_latency got %0d exp 2", n); end
      checks++; if (if_pc !== exp) begin errors++; $display("FAIL seq_pc got %h exp %h", if_pc, exp); end
      checks++; if (if_instr !== mem_word(exp)) begin errors++; $display("FAIL seq_instr got %h exp %h", if_instr, mem_word(exp)); end
      checks++; if (if_adel !== 1'b0) begin errors++; $display("FAIL seq_adel got %b exp 0", if_adel); end
    end
  endtask

  task automatic test_redirect_wait();
    int n;
    do_reset();
    mem_lat = 2; im_gnt = 1'b1; if_ready = 1'b0;
    @(negedge CLK);
    br_taken = 1'b1; br_target = 32'h3100;
    @(negedge CLK);
    br_taken = 1'b0;
    checks++; if (im_req !== 1'b0) begin errors++; $display("FAIL rw_req_wait got %b exp 0", im_req); end
    repeat (2) @(negedge CLK);
    checks++; if (im_req !== 1'b1) begin errors++; $display("FAIL rw_req got %b exp 1", im_req); end
    checks++; if (im_addr !== 32'h3100) begin errors++; $display("FAIL rw_addr got %h exp 3100", im_addr); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rw_stale_valid got %b exp 0", if_valid); end
    n = 0;
    while (if_valid !== 1'b1 && n < 12) begin @(negedge CLK); n++; end
    checks++; if (n !== 4) begin errors++; $display("FAIL rw_latency got %0d exp 4", n); end
    checks++; if (if_pc !== 32'h3100) begin errors++; $display("FAIL rw_pc got %h exp 3100", if_pc); end
    checks++; if (if_instr !== mem_word(32'h3100)) begin errors++; $display("FAIL rw_instr got %h exp %h", if_instr, mem_word(32'h3100)); end
  endtask

  task automatic test_priority();
    do_reset();
    im_gnt = 1'b0;
    eret = 1'b1; epc = 32'h3020; exc_req = 1'b1; br_taken = 1'b1; br_target = 32'h3100;
    @(negedge CLK);
    eret = 1'b0;
    checks++; if (im_addr !== 32'h3020) begin errors++; $display("FAIL pri_eret got %h exp 3020", im_addr); end
    checks++; if (im_req !== 1'b1) begin errors++; $display("FAIL pri_req got %b exp 1", im_req); end
    @(negedge CLK);
    exc_req = 1'b0; br_taken = 1'b0;
    checks++; if (im_addr !== 32'h4180) begin errors++; $display("FAIL pri_exc got %h exp 4180", im_addr); end
  endtask

  task automatic test_adel();
    do_reset();
    im_gnt = 1'b0; if_ready = 1'b0;
    br_taken = 1'b1; br_target = 32'h6ffc;
    @(negedge CLK);
    checks++; if (im_req !== 1'b1) begin errors++; $display("FAIL adel_hi_legal got %b exp 1", im_req); end
    br_target = 32'h7000;
    @(negedge CLK);
    checks++; if (im_req !== 1'b0) begin errors++; $display("FAIL adel_above got %b exp 0", im_req); end
    br_target = 32'h2ffc;
    @(negedge CLK);
    checks++; if (im_req !== 1'b0) begin errors++; $display("FAIL adel_below got %b exp 0", im_req); end
    br_target = 32'h3002;
    @(negedge CLK);
    br_taken = 1'b0;
    checks++; if (im_req !== 1'b0) begin errors++; $display("FAIL adel_misal got %b exp 0", im_req); end
    @(negedge CLK);
    checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL adel_valid got %b exp 1", if_valid); end
    checks++; if (if_adel !== 1'b1) begin errors++; $display("FAIL adel_flag got %b exp 1", if_adel); end
    checks++; if (if_pc !== 32'h3002) begin errors++; $display("FAIL adel_pc got %h exp 3002", if_pc); end
    checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL adel_instr got %h exp 0", if_instr); end
    exc_req = 1'b1;
    @(negedge CLK);
    exc_req = 1'b0;
    checks++; if (im_addr !== 32'h4180) begin errors++; $display("FAIL adel_exc_addr got %h exp 4180", im_addr); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL adel_flush got %b exp 0", if_valid); end
  endtask

  task automatic test_hold_flush();
    int n;
    do_reset();
    mem_lat = 0; im_gnt = 1'b1; if_ready = 1'b0;
    n = 0;
    while (if_valid !== 1'b1 && n < 10) begin @(negedge CLK); n++; end
    checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL hold_timeout got %b exp 1", if_valid); end
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      checks++;
      if (if_valid !== 1'b1 || im_req !== 1'b0 || if_pc !== 32'h3000 || if_instr !== mem_word(32'h3000)) begin
        errors++;
        $display("FAIL hold_stable c=%0d valid=%b req=%b pc=%h instr=%h exp 1 0 3000 %h",
                 c, if_valid, im_req, if_pc, if_instr, mem_word(32'h3000));
      end
    end
    exc_req = 1'b1;
    @(negedge CLK);
    exc_req = 1'b0;
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL hold_flush got %b exp 0", if_valid); end
    checks++; if (im_addr !== 32'h4180) begin errors++; $display("FAIL hold_flush_addr got %h exp 4180", im_addr); end
  endtask

  task automatic test_reset_in_wait();
    int n;
    do_reset();
    mem_lat = 3; im_gnt = 1'b1; if_ready = 1'b1;
    @(negedge CLK);
    Reset = 1'b1;
    @(negedge CLK);
    Reset = 1'b0; mem_lat = 0;
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rstw_valid got %b exp 0", if_valid); end
    checks++; if (im_req !== 1'b1) begin errors++; $display("FAIL rstw_req got %b exp 1", im_req); end
    checks++; if (im_addr !== 32'h3000) begin errors++; $display("FAIL rstw_addr got %h exp 3000", im_addr); end
    n = 0;
    while (if_valid !== 1'b1 && n < 10) begin @(negedge CLK); n++; end
    checks++; if (if_pc !== 32'h3000 || n !== 2) begin errors++; $display("FAIL rstw_refetch got pc=%h lat=%0d exp 3000 2", if_pc, n); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_redirect_wait();
    test_priority();
    test_adel();
    test_hold_flush();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
